// File: rtl/gpr_seq_pkg.sv
// Shared constants and enumerations for the gpr bit-serial operation sequencer.
package gpr_seq_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_SRA  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/gpr_seq_serial_fa.sv
// Bit-serial full adder: combinational sum and next carry, with a carry flop
// that can be preset (0 for ADD, 1 for SUB) before the first bit.
module serial_fa (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_init,
  input  logic i_cinit,
  input  logic i_en,
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_cout
);

  logic carry_q;
  logic carry_d;

  assign o_sum   = i_a ^ i_b ^ carry_q;
  assign o_cout  = (i_a & i_b) | (i_a & carry_q) | (i_b & carry_q);

  always_comb begin
    carry_d = carry_q;
    if (i_init) begin
      carry_d = i_cinit;
    end else if (i_en) begin
      carry_d = o_cout;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/gpr_seq.sv
// Sequencer driving the two-entry shift-register file gpr: LOAD, ADD, SUB and
// arithmetic shift right, one bit per cycle, with carry/zero flags and a done pulse.
module gpr_seq
  import gpr_seq_pkg::*;
#(
  parameter int WIDTH = gpr_seq_pkg::WIDTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic [1:0]                 i_cmd_op,
  input  logic                       i_cmd_dst,
  input  logic [WIDTH-1:0]           i_cmd_imm,
  input  logic [$clog2(WIDTH)-1:0]   i_cmd_amt,
  input  logic                       i_gpr_bit,
  input  logic [WIDTH-1:0]           i_ry,
  input  logic [WIDTH-1:0]           i_rx,
  output logic                       o_con_shift,
  output logic                       o_con_sign,
  output logic                       o_data_in,
  output logic                       o_data_sign,
  output logic                       o_rd_addr,
  output logic                       o_done,
  output logic                       o_flag_c,
  output logic                       o_flag_z
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              op_q;
  logic             dst_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] src_q;
  logic [CW-1:0]    amt_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q;
  logic             zacc_q;
  logic             pend_z_q;
  logic             pend_c_q;
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;

  op_e              cmd_op;
  logic             accept;
  logic [WIDTH-1:0] dst_val;
  logic [WIDTH-1:0] src_val;
  logic [CW-1:0]    amt_m1_in;
  logic             sra_c_in;
  logic             sra_z_in;
  logic [CW-1:0]    last_cnt;
  logic             is_last;
  logic             is_arith;
  logic             in_run;
  logic             fa_b;
  logic             fa_sum;
  logic             fa_cout;

  assign cmd_op   = op_e'(i_cmd_op);
  assign accept   = i_cmd_valid && (state_q == IDLE);
  assign dst_val  = i_cmd_dst ? i_rx : i_ry;
  assign src_val  = i_cmd_dst ? i_ry : i_rx;

  // SRA flags come straight from the pre-shift destination value.
  assign amt_m1_in = i_cmd_amt - CW'(1);
  assign sra_c_in  = (i_cmd_amt != '0) & dst_val[amt_m1_in];
  assign sra_z_in  = ((dst_val >> i_cmd_amt) == '0);

  assign last_cnt = (op_q == OP_SRA) ? (amt_q - CW'(1)) : CNT_LAST;
  assign is_last  = (cnt_q == last_cnt);
  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign in_run   = (state_q == RUN);

  // SUB is ADD of the inverted source with the carry preset to 1.
  assign fa_b = src_q[cnt_q] ^ (op_q == OP_SUB);

  serial_fa u_fa (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_init  (accept),
    .i_cinit (cmd_op == OP_SUB),
    .i_en    (in_run && is_arith),
    .i_a     (i_gpr_bit),
    .i_b     (fa_b),
    .o_sum   (fa_sum),
    .o_cout  (fa_cout)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;
    o_cmd_ready = 1'b0;
    o_con_shift = 1'b0;
    o_con_sign  = 1'b0;
    o_data_in   = 1'b0;
    o_data_sign = 1'b0;
    o_rd_addr   = 1'b0;
    o_done      = 1'b0;
    case (state_q)
      IDLE: begin
        o_cmd_ready = 1'b1;
        cnt_d       = '0;
        if (i_cmd_valid) begin
          if ((cmd_op == OP_SRA) && (i_cmd_amt == '0)) begin
            state_d  = DONE;
            flag_c_d = 1'b0;
            flag_z_d = sra_z_in;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        o_con_shift = 1'b1;
        o_rd_addr   = dst_q;
        case (op_q)
          OP_LOAD: o_data_in = imm_q[cnt_q];
          OP_ADD,
          OP_SUB:  o_data_in = fa_sum;
          OP_SRA: begin
            o_con_sign  = 1'b1;
            o_data_sign = sign_q;
          end
          default: o_data_in = 1'b0;
        endcase
        cnt_d = cnt_q + CW'(1);
        if (is_last) begin
          state_d = DONE;
          cnt_d   = '0;
          if (is_arith) begin
            flag_c_d = fa_cout;
            flag_z_d = zacc_q & ~fa_sum;
          end else begin
            flag_c_d = pend_c_q;
            flag_z_d = pend_z_q;
          end
        end
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_LOAD;
      dst_q    <= 1'b0;
      imm_q    <= '0;
      src_q    <= '0;
      amt_q    <= '0;
      sign_q   <= 1'b0;
      zacc_q   <= 1'b0;
      pend_z_q <= 1'b0;
      pend_c_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      if (accept) begin
        op_q     <= cmd_op;
        dst_q    <= i_cmd_dst;
        imm_q    <= i_cmd_imm;
        src_q    <= src_val;
        amt_q    <= i_cmd_amt;
        sign_q   <= dst_val[WIDTH-1];
        zacc_q   <= 1'b1;
        pend_z_q <= (cmd_op == OP_SRA) ? sra_z_in : (i_cmd_imm == '0);
        pend_c_q <= (cmd_op == OP_SRA) ? sra_c_in : 1'b0;
      end else if (in_run && is_arith) begin
        zacc_q <= zacc_q & ~fa_sum;
      end
    end
  end

  assign o_flag_c = flag_c_q;
  assign o_flag_z = flag_z_q;

endmodule

// File: tb/tb_gpr_seq.sv
// Bench for gpr_seq with a behavioural gpr model; expected results are queued
// when a command is driven and checked when o_done pulses.
module tb_gpr_seq;

  localparam logic [1:0] L = 2'b00;
  localparam logic [1:0] A = 2'b01;
  localparam logic [1:0] S = 2'b10;
  localparam logic [1:0] R = 2'b11;

  typedef struct {
    logic [7:0] ry;
    logic [7:0] rx;
    logic       c;
    logic       z;
    int         lat;
    int         shifts;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic       dst;
    logic [7:0] imm;
    logic [2:0] amt;
    logic [7:0] pre_ry;
    logic [7:0] pre_rx;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_dst;
  logic [7:0] cmd_imm;
  logic [2:0] cmd_amt;
  logic       gpr_bit;
  logic       con_shift, con_sign, data_in, data_sign, rd_addr, done, flag_c, flag_z;

  logic [7:0] sr0, sr1;
  logic       pre_en;
  logic [7:0] pre_ry, pre_rx;

  int   n_vec = 0;
  int   n_mis = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  gpr_seq dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_dst   (cmd_dst),
    .i_cmd_imm   (cmd_imm),
    .i_cmd_amt   (cmd_amt),
    .i_gpr_bit   (gpr_bit),
    .i_ry        (sr0),
    .i_rx        (sr1),
    .o_con_shift (con_shift),
    .o_con_sign  (con_sign),
    .o_data_in   (data_in),
    .o_data_sign (data_sign),
    .o_rd_addr   (rd_addr),
    .o_done      (done),
    .o_flag_c    (flag_c),
    .o_flag_z    (flag_z)
  );

  // gpr model: selected register shifts right, new MSB from sign or serial data.
  assign gpr_bit = rd_addr ? sr1[0] : sr0[0];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_en) begin
      sr0 <= pre_ry;
      sr1 <= pre_rx;
    end else if (con_shift) begin
      if (rd_addr) sr1 <= {(con_sign ? data_sign : data_in), sr1[7:1]};
      else         sr0 <= {(con_sign ? data_sign : data_in), sr0[7:1]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: track accept cycle and shift count, score each completion.
  int acc_cyc = 0;
  int shifts  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && cmd_valid && cmd_ready) begin
      acc_cyc = cyc + 1;
      shifts  = 0;
    end
    if (con_shift) begin
      shifts++;
      chk("ready_low_in_run", {31'd0, cmd_ready}, 32'd0);
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ry", {24'd0, sr0}, {24'd0, e.ry});
        chk("rx", {24'd0, sr1}, {24'd0, e.rx});
        chk("flag_c", {31'd0, flag_c}, {31'd0, e.c});
        chk("flag_z", {31'd0, flag_z}, {31'd0, e.z});
        chk("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
        chk("shift_cycles", 32'(shifts), 32'(e.shifts));
        $display("done: ry=%02h rx=%02h c=%0b z=%0b lat=%0d shifts=%0d",
                 sr0, sr1, flag_c, flag_z, cyc - acc_cyc + 1, shifts);
      end
    end
  end

  task automatic preload(input logic [7:0] ry, input logic [7:0] rx);
    pre_ry = ry;
    pre_rx = rx;
    pre_en = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic wait_accept();
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      chk("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    #1;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic dst, input logic [7:0] imm,
                         input logic [2:0] amt, input exp_t e);
    cmd_op    = op;
    cmd_dst   = dst;
    cmd_imm   = imm;
    cmd_amt   = amt;
    cmd_valid = 1'b1;
    exp_q.push_back(e);
    $display("cmd: op=%0d dst=%0d imm=%02h amt=%0d ry=%02h rx=%02h", op, dst, imm, amt, sr0, sr1);
    wait_accept();
    cmd_valid = 1'b0;
    drain();
  endtask

  vec_t vt[12];

  initial begin
    bit seen;
    //             op dst imm    amt   pre_ry pre_rx  ry     rx     c     z    lat sh
    vt[0]  = '{L, 1'b0, 8'hA5, 3'd0, 8'h3C, 8'h11, '{8'hA5, 8'h11, 1'b0, 1'b0, 9, 8}};
    vt[1]  = '{L, 1'b1, 8'h00, 3'd0, 8'hA5, 8'h11, '{8'hA5, 8'h00, 1'b0, 1'b1, 9, 8}};
    vt[2]  = '{A, 1'b0, 8'h00, 3'd0, 8'hF0, 8'h20, '{8'h10, 8'h20, 1'b1, 1'b0, 9, 8}};
    vt[3]  = '{A, 1'b0, 8'h00, 3'd0, 8'h01, 8'hFF, '{8'h00, 8'hFF, 1'b1, 1'b1, 9, 8}};
    vt[4]  = '{S, 1'b0, 8'h00, 3'd0, 8'h05, 8'h07, '{8'hFE, 8'h07, 1'b0, 1'b0, 9, 8}};
    vt[5]  = '{S, 1'b0, 8'h00, 3'd0, 8'h07, 8'h07, '{8'h00, 8'h07, 1'b1, 1'b1, 9, 8}};
    vt[6]  = '{R, 1'b1, 8'h00, 3'd3, 8'h55, 8'h90, '{8'h55, 8'hF2, 1'b0, 1'b0, 4, 3}};
    vt[7]  = '{R, 1'b1, 8'h00, 3'd0, 8'h55, 8'h00, '{8'h55, 8'h00, 1'b0, 1'b1, 1, 0}};
    vt[8]  = '{A, 1'b1, 8'h00, 3'd0, 8'h3A, 8'h47, '{8'h3A, 8'h81, 1'b0, 1'b0, 9, 8}};
    vt[9]  = '{R, 1'b0, 8'h00, 3'd7, 8'h6B, 8'h00, '{8'h00, 8'h00, 1'b1, 1'b1, 8, 7}};
    vt[10] = '{R, 1'b1, 8'h00, 3'd1, 8'h00, 8'h81, '{8'h00, 8'hC0, 1'b1, 1'b0, 2, 1}};
    vt[11] = '{S, 1'b1, 8'h00, 3'd0, 8'h01, 8'h00, '{8'h01, 8'hFF, 1'b0, 1'b0, 9, 8}};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = L; cmd_dst = 1'b0;
    cmd_imm = 8'h00; cmd_amt = 3'd0; pre_en = 1'b0; pre_ry = 8'h00; pre_rx = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {23'd0, cmd_ready, con_shift, con_sign, data_in, data_sign,
                          rd_addr, done, flag_c, flag_z}, 32'h100);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      preload(vt[i].pre_ry, vt[i].pre_rx);
      run_cmd(vt[i].op, vt[i].dst, vt[i].imm, vt[i].amt, vt[i].e);
    end

    // Back-to-back: valid held high, second command staged during the first's RUN.
    preload(8'h10, 8'h03);
    exp_q.push_back('{8'h13, 8'h03, 1'b0, 1'b0, 9, 8});
    exp_q.push_back('{8'h04, 8'h03, 1'b1, 1'b0, 3, 2});
    cmd_op = A; cmd_dst = 1'b0; cmd_imm = 8'h00; cmd_amt = 3'd0; cmd_valid = 1'b1;
    $display("cmd: back-to-back ADD then SRA amt=2");
    wait_accept();
    cmd_op = R; cmd_dst = 1'b0; cmd_amt = 3'd2; cmd_imm = 8'h77;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("b2b_first_done_seen", {31'd0, seen}, 32'd1);
    chk("b2b_ready_in_done", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_ready_after_done", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_op = L; cmd_dst = 1'b1; cmd_imm = 8'hFF; cmd_amt = 3'd5;
    @(negedge clk);
    chk("b2b_second_running", {31'd0, con_shift}, 32'd1);
    drain();

    // Reset at RUN cycle k=4 of an ADD, with z=1 left by the preceding LOAD.
    run_cmd(L, 1'b1, 8'h00, 3'd0, '{8'h04, 8'h00, 1'b0, 1'b1, 9, 8});
    cmd_op = A; cmd_dst = 1'b0; cmd_valid = 1'b1;
    $display("cmd: ADD with reset at k=4");
    wait_accept();
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_pre_shift", {31'd0, con_shift}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mid_run_outputs", {23'd0, cmd_ready, con_shift, con_sign, data_in, data_sign,
                                rd_addr, done, flag_c, flag_z}, 32'h100);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("rst_no_done", {31'd0, seen}, 32'd0);
    chk("rst_idle_ready", {31'd0, cmd_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/gpr_seq.md
Name: gpr_seq

Overview:
Bit-serial operation sequencer for the two-entry 8-bit shift-register file gpr (sr[0]=ry, sr[1]=rx).
- Accepts one command at a time over a valid/ready handshake: LOAD immediate, ADD, SUB, or arithmetic shift right.
- Drives the gpr shift/sign/address/serial-data controls for the required number of cycles.
- Computes ADD/SUB with a bit-serial adder, reports carry/zero flags, and pulses o_done on completion.

Parameters:
WIDTH, 8, register width; must equal the gpr width. Counter width is $clog2(WIDTH).

Ports:
i_clk  in  1  clock; one clock domain.
i_rst_n  in  1  reset; synchronous, active-low.
i_cmd_valid  in  1  command present.
o_cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
i_cmd_op  in  2  00 LOAD, 01 ADD, 10 SUB, 11 SRA.
i_cmd_dst  in  1  destination register address (0=ry, 1=rx); the other register is the source.
i_cmd_imm  in  8  LOAD immediate.
i_cmd_amt  in  3  SRA shift amount, 0..7.
i_gpr_bit  in  1  gpr o_data_out, the current dst LSB.
i_ry  in  8  gpr ry parallel bus.
i_rx  in  8  gpr rx parallel bus.
o_con_shift  out  1  to gpr i_con_shift.
o_con_sign  out  1  to gpr i_con_sign.
o_data_in  out  1  to gpr i_data_in.
o_data_sign  out  1  to gpr i_data_sign.
o_rd_addr  out  1  to gpr rd_addr.
o_done  out  1  one-cycle completion pulse.
o_flag_c  out  1  carry flag of the last completed command.
o_flag_z  out  1  zero flag of the last completed command.

Behaviour:
- Reset (i_rst_n low at a clock edge): state IDLE; counter, carry and pending regs 0; all outputs 0 except o_cmd_ready=1.
- Reset mid-RUN aborts the command; o_con_shift is low from the next cycle. gpr contents stay partially shifted (not restored).
- States are IDLE, RUN, DONE.
- Accept: i_cmd_valid && o_cmd_ready at edge T. On that edge, latch op, dst, imm and amt, and capture the source operand src = (dst ? i_ry : i_rx).
- IDLE -> RUN on accept, except SRA with amt=0, which goes IDLE -> DONE.
- RUN: o_con_shift=1 and o_rd_addr=dst_q. Counter k runs 0..N-1; RUN -> DONE when k=N-1.
- N is WIDTH for LOAD/ADD/SUB and amt for SRA.
- DONE: o_done=1 for one cycle, then IDLE. o_cmd_ready is 0 in RUN and DONE.
- Latency: LOAD/ADD/SUB shift at T+1..T+8 and o_done at T+9. SRA shifts at T+1..T+amt and o_done at T+amt+1.
- Back-to-back: the earliest next accept is at the edge after o_done.
- LOAD: o_con_sign=0, o_data_in=imm_q[k]. Registered at accept: pending z=(imm==0), c=0.
- ADD: a=i_gpr_bit, b=src_q[k], o_data_in=a^b^c. Carry reg starts at 0; each RUN cycle c<=maj(a,b,c).
- SUB: same datapath with b inverted and carry starting at 1. The final carry is 1 when there is no borrow.
- ADD/SUB zero: z accumulator starts at 1 and is cleared by any 1 sum bit.
- SRA: o_con_sign=1. o_data_sign is the dst bit 7 captured at accept; its value is held.
- SRA flags, registered at accept: pending z=((dst_val>>amt)==0); pending c = (amt==0) ? 0 : dst_val[amt-1].
- Flags update on the edge entering DONE, so they are valid while o_done=1, and hold until the next DONE.
- o_con_sign=0 and o_data_in=0 outside RUN; o_data_sign=0 outside RUN.
- The ADD/SUB source bus is stable during RUN because gpr shifts only the register selected by o_rd_addr.
- dst_q and src_q are registered, so input changes during RUN have no effect.

Decomposition:
- Package gpr_seq_pkg holds: the WIDTH constant; op_e enum (OP_LOAD, OP_ADD, OP_SUB, OP_SRA); state_e enum (IDLE, RUN, DONE).
- Sub-module serial_fa: a bit-serial full adder with carry flop, carry-init input (0 or 1) and enable. It is instantiated once.

Test Plan:
- Reset, then LOAD dst=0 imm=8'hA5 -> gpr ry=8'hA5 after 8 shift cycles; o_done at T+9; c=0, z=0. Then LOAD dst=1 imm=0 -> rx=0, z=1.
- ry=8'hF0, rx=8'h20, ADD dst=0 -> ry=8'h10, c=1, z=0. With ry=8'h01, rx=8'hFF -> ry=8'h00, c=1, z=1.
- ry=8'h05, rx=8'h07, SUB dst=0 -> ry=8'hFE, c=0. With ry=8'h07, rx=8'h07 -> ry=0, c=1, z=1.
- rx=8'h90, SRA dst=1 amt=3 -> exactly 3 shift cycles, rx=8'hF2, c=0, o_done at T+4. With amt=0 -> no shift, o_done at T+1, rx unchanged.
- Hold i_cmd_valid high with 2 queued commands -> o_cmd_ready low in RUN/DONE, second accept exactly at the edge after o_done; i_cmd_* changes mid-RUN are ignored.
- Assert i_rst_n low at RUN cycle k=4 of ADD -> IDLE and o_con_shift=0 next cycle, o_done never pulses, flags=0, o_cmd_ready=1.
